// File: rtl/div_check_if.sv
// Handshake and operand/result bundle for the div_check reconstruction checker.
interface div_check_if #(
  parameter int DATAWIDTH = 64
);
  logic                 Start;
  logic [DATAWIDTH-1:0] Q;
  logic [DATAWIDTH-1:0] B;
  logic [DATAWIDTH-1:0] R;
  logic [DATAWIDTH-1:0] A;
  logic                 Busy;
  logic                 Done;
  logic [DATAWIDTH-1:0] Prod;
  logic                 Overflow;
  logic                 Match;

  modport master (
    output Start, Q, B, R, A,
    input  Busy, Done, Prod, Overflow, Match
  );

  modport slave (
    input  Start, Q, B, R, A,
    output Busy, Done, Prod, Overflow, Match
  );
endinterface

// File: rtl/div_check.sv
// div_check: recomputes Q*B + R with a one-bit-per-clock shift-add multiplier
// and reports whether the (Q, R) pair reconstructs the expected dividend A and
// is a legal division result (B != 0, R < B, no overflow).
module div_check #(
  parameter int DATAWIDTH = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  div_check_if.slave  bus
);

  localparam int                CNT_W     = $clog2(DATAWIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATAWIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, CHECK} state_e;

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   q_sh_q, q_sh_d;     // multiplier, consumed LSB first
  logic [DATAWIDTH-1:0]   b_q, b_d;           // original divisor for legality test
  logic [DATAWIDTH-1:0]   r_q, r_d;
  logic [DATAWIDTH-1:0]   a_q, a_d;
  logic [2*DATAWIDTH-1:0] acc_q, acc_d;       // wide enough that Q*B + R never wraps
  logic [2*DATAWIDTH-1:0] b_sh_q, b_sh_d;     // divisor shifted to current bit weight
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [DATAWIDTH-1:0]   prod_q, prod_d;
  logic                   ovf_q, ovf_d;
  logic                   match_q, match_d;
  logic                   acc_hi_nz;

  assign acc_hi_nz = |acc_q[2*DATAWIDTH-1:DATAWIDTH];

  // Next-state and datapath: latch in IDLE, shift-add in MUL, grade in CHECK.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    q_sh_d  = q_sh_q;
    b_d     = b_q;
    r_d     = r_q;
    a_d     = a_q;
    acc_d   = acc_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    match_d = match_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          q_sh_d  = bus.Q;
          b_d     = bus.B;
          r_d     = bus.R;
          a_d     = bus.A;
          acc_d   = {{DATAWIDTH{1'b0}}, bus.R};
          b_sh_d  = {{DATAWIDTH{1'b0}}, bus.B};
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (q_sh_q[0]) begin
          acc_d = acc_q + b_sh_q;
        end
        q_sh_d = q_sh_q >> 1;
        b_sh_d = b_sh_q << 1;
        cnt_d  = cnt_q + 1'b1;
        // Fixed latency: always run all DATAWIDTH iterations.
        if (cnt_q == LAST_ITER) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        prod_d  = acc_q[DATAWIDTH-1:0];
        ovf_d   = acc_hi_nz;
        match_d = (b_q != '0) && (r_q < b_q) && !acc_hi_nz &&
                  (acc_q[DATAWIDTH-1:0] == a_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      q_sh_q  <= '0;
      b_q     <= '0;
      r_q     <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values together.
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      b_q     <= b_d;
      r_q     <= r_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  // Busy covers MUL and CHECK, so it drops on the same edge that raises Done.
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = done_q;
  assign bus.Prod     = prod_q;
  assign bus.Overflow = ovf_q;
  assign bus.Match    = match_q;

endmodule

// File: doc/div_check.md
# div_check

Sequential reconstruction checker: the inverse of the DIV/MOD datapath. It takes a quotient Q, divisor B, remainder R and expected dividend A, and recomputes Q*B + R with a shift-add multiplier, one multiplier bit per clock. It then reports the reconstructed value, whether it matches A, and whether the (Q, R) pair is a legal division result. It sits downstream of DIV/MOD instances in the scheduled circuits as a self-check and result-validation stage.

## Interface
- DATAWIDTH, 64, width of Q, B, R, A and Prod.
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Q  input  DATAWIDTH  quotient (unsigned).
- B  input  DATAWIDTH  divisor (unsigned).
- R  input  DATAWIDTH  remainder (unsigned).
- A  input  DATAWIDTH  expected dividend (unsigned).
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; result outputs valid from this cycle on.
- Prod  output  DATAWIDTH  low DATAWIDTH bits of Q*B + R.
- Overflow  output  1  Q*B + R does not fit in DATAWIDTH bits.
- Match  output  1  reconstruction is equal to A and the division result is legal.

## Operation
- States: IDLE, MUL, CHECK.
- IDLE: when Start=1, latch Q, B, R and A. Load the accumulator (2*DATAWIDTH bits) with R zero-extended. Load the shift register with B zero-extended to 2*DATAWIDTH. Clear the bit counter. Move to MUL.
- MUL: each cycle, if the current LSB of the latched Q is 1, add the shift register to the accumulator. Then shift Q right by 1 and the B register left by 1, and increment the counter.
  - After exactly DATAWIDTH iterations, move to CHECK.
  - There is no early exit: latency is the same for all operand values.
- CHECK (single cycle): register the results, pulse Done, return to IDLE.
  - Prod = acc[DATAWIDTH-1:0].
  - Overflow = |acc[2*DATAWIDTH-1:DATAWIDTH].
  - Match = (B != 0) && (R < B) && !Overflow && (acc[DATAWIDTH-1:0] == A).
- Division by zero (B = 0): Match=0 always. Prod = R. Overflow=0.
- All arithmetic is unsigned. The accumulator never wraps, because Q*B + R < 2^(2*DATAWIDTH).
- Start while Busy=1 is ignored. Input changes during MUL are ignored, because operands are latched.
- Prod, Overflow and Match hold their values until the next CHECK. They are not cleared by a new Start.

## Timing
- Reset value of every output: 0. Reset also forces state IDLE and clears internal registers.
- Asserting Rst mid-operation aborts the operation: no Done, outputs return to 0.
- Start sampled high at edge 0:
  - Busy=1 from edge 0.
  - Iterations occur at edges 1..DATAWIDTH.
  - CHECK occurs at edge DATAWIDTH+1. At that edge Done=1, Busy=0, and the results update.
- Latency from the Start edge to Done: DATAWIDTH+1 clocks.
- Done falls at edge DATAWIDTH+2.
- Back-to-back operation: Start high during the Done cycle is accepted, because the block is in IDLE. This gives a throughput of one operation per DATAWIDTH+2 clocks.
- Busy and Done are never high in the same cycle.

## Test plan
- DATAWIDTH=8, Q=7, B=9, R=4, A=67 -> Done exactly 9 clocks after the Start edge; Prod=67, Match=1, Overflow=0.
- DATAWIDTH=8, Q=7, B=9, R=4, A=66 -> Prod=67, Match=0, Overflow=0.
- DATAWIDTH=8, Q=20, B=20, R=0, A=144 -> Prod=144 (400 mod 256), Overflow=1, Match=0.
- DATAWIDTH=8 illegal cases, both with Overflow=0:
  - Q=3, B=5, R=5, A=20 -> Prod=20, Match=0 (R not < B).
  - Q=3, B=0, R=2, A=2 -> Prod=2, Match=0 (divide by zero).
- DATAWIDTH=64, Q=2^32, B=2^32-1, R=5, A=2^64-2^32+5 -> Prod=A, Match=1. Done is 65 clocks after Start; Busy is high for exactly 65 cycles.
- DATAWIDTH=8 control sequencing:
  - Start pulses at cycles 3 and 5 -> only the first is accepted.
  - Start held during the Done cycle -> a second op starts, and its Done comes 9 clocks later.
  - Rst low at iteration 4 -> all outputs 0, no Done.
  - The next Start completes normally.
